// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI bridges: bus widths, fixed AXI
// encodings, bridge FSM states and the latched request payload.
package cache_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 2;

    localparam logic [1:0]       AXI_BURST_INCR = 2'b01;
    localparam logic [LEN_W-1:0] AXI_LEN_SINGLE = LEN_W'(0);

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } bridge_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } cache_req_t;

    // Cache-side size (bytes = 2**size) maps straight onto AxSIZE.
    function automatic logic [2:0] axi_size(input logic [SIZE_W-1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/strb_gen.sv
// Byte-lane write strobe from transfer size and the low address bits.
module strb_gen
    import cache_axi_pkg::*;
(
    input  logic [SIZE_W-1:0] size_i,
    input  logic [1:0]        addr_lo_i,
    output logic [STRB_W-1:0] strb_o
);

    always_comb begin
        strb_o = '1;
        case (size_i)
            SIZE_BYTE: strb_o = STRB_W'(4'b0001 << addr_lo_i);
            SIZE_HALF: strb_o = addr_lo_i[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
            default:   strb_o = '1;
        endcase
    end

endmodule

// File: rtl/icache_axi_bridge.sv
// Single-outstanding bridge from the i-cache sram-like port to AXI single-beat
// reads and writes.
module icache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] RD_ID = 4'd0,
    parameter logic [ID_W-1:0] WR_ID = 4'd1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cache_inst_req,
    input  logic                cache_inst_wr,
    input  logic [SIZE_W-1:0]   cache_inst_size,
    input  logic [ADDR_W-1:0]   cache_inst_addr,
    input  logic [DATA_W-1:0]   cache_inst_wdata,
    output logic [DATA_W-1:0]   cache_inst_rdata,
    output logic                cache_inst_addr_ok,
    output logic                cache_inst_data_ok,

    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [STRB_W-1:0]   wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    bridge_state_e state_q, state_d;
    cache_req_t    req_q, req_d;

    logic arvalid_q, arvalid_d;
    logic rready_q,  rready_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q,  wvalid_d;
    logic bready_q,  bready_d;

    logic              accept_c;
    logic              data_ok_c;
    logic [STRB_W-1:0] strb_c;

    // Response IDs and error codes are intentionally not acted upon.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, bid, bresp};

    assign accept_c = cache_inst_req & (state_q == IDLE);

    // Next-state, payload capture and handshake bookkeeping.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        data_ok_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (cache_inst_req) begin
                    req_d.addr  = cache_inst_addr;
                    req_d.size  = cache_inst_size;
                    req_d.wr    = cache_inst_wr;
                    req_d.wdata = cache_inst_wdata;
                    if (cache_inst_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (rvalid && rlast) begin
                    data_ok_c = 1'b1;
                    rready_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            AW_W: begin
                // Address and data channels retire independently, in any order.
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (bvalid) begin
                    data_ok_c = 1'b1;
                    bready_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    strb_gen u_strb_gen (
        .size_i    (req_q.size),
        .addr_lo_i (req_q.addr[1:0]),
        .strb_o    (strb_c)
    );

    assign cache_inst_addr_ok = accept_c;
    // A response landing in a reset cycle belongs to an abandoned transaction.
    assign cache_inst_data_ok = data_ok_c & ~rst;
    assign cache_inst_rdata   = rdata;

    assign arid    = RD_ID;
    assign araddr  = req_q.addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = axi_size(req_q.size);
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = WR_ID;
    assign awaddr  = req_q.addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size(req_q.size);
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    assign wid     = WR_ID;
    assign wdata   = req_q.wdata;
    assign wstrb   = req_q.wr ? strb_c : '0;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: doc/icache_axi_bridge.md
ICACHE_AXI_BRIDGE -- requirements
Module: icache_axi_bridge

Interface
REQ-001 Parameter: RD_ID, 4'd0, AXI ID driven on arid.
REQ-002 Parameter: WR_ID, 4'd1, AXI ID driven on awid and wid.
REQ-003 Port: clk  in  1  single clock; all logic on posedge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Ports, cache side (sram-like slave):
- cache_inst_req  in  1
- cache_inst_wr  in  1
- cache_inst_size  in  2  (0=byte, 1=half, 2=word)
- cache_inst_addr  in  32
- cache_inst_wdata  in  32
- cache_inst_rdata  out  32
- cache_inst_addr_ok  out  1
- cache_inst_data_ok  out  1
REQ-006 Ports, AXI read: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1, rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-007 Ports, AXI write: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1, wid out 4, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1, bid in 4, bresp in 2, bvalid in 1, bready out 1.

Function
REQ-010 The block SHALL hold at most one outstanding transaction; FSM states IDLE, AR, R, AW_W, B.
REQ-011 cache_inst_addr_ok SHALL equal cache_inst_req & (state==IDLE), combinationally; it SHALL be 0 in every other state.
REQ-012 On addr_ok, the block SHALL latch addr, size, wr and wdata, then move to AR (wr=0) or AW_W (wr=1).
REQ-013 AR: arvalid=1, araddr=latched addr; AR->R on arvalid&arready.
REQ-014 R: rready=1; on rvalid&rlast, data_ok=1 for exactly that cycle, cache_inst_rdata=rdata (pass-through), and R->IDLE.
REQ-015 AW_W: awvalid and wvalid SHALL rise together on entry.
- Each SHALL drop independently after its own handshake.
- AW_W->B in the cycle where both handshakes have completed (same cycle or in either order).
REQ-016 B: bready=1; on bvalid, data_ok=1 for that cycle and B->IDLE.
REQ-017 Fixed encodings: arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=awsize={1'b0,size}.
REQ-018 wstrb from latched size/addr[1:0]:
- byte: one-hot at addr[1:0]
- half: 4'b0011 if addr[1]=0, else 4'b1100
- word: 4'b1111
REQ-019 wdata SHALL be the latched wdata, unshifted.
REQ-020 rresp/bresp errors SHALL be ignored; data_ok is still returned. rid/bid are not checked.
REQ-021 A new request SHALL be accepted in IDLE only: minimum turnaround of one IDLE cycle after data_ok.
REQ-022 Latency with zero-wait slave:
- read: addr_ok cycle N, arvalid N+1, data_ok N+2
- write: data_ok N+2 if B returns in the same cycle as W accept, else later
REQ-023 Inputs that change after addr_ok SHALL NOT affect the in-flight transaction.

Reset
REQ-030 On rst, the next state SHALL be IDLE.
REQ-031 The following SHALL be 0 after reset: arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok, and all latched registers.
REQ-032 Reset mid-transaction SHALL abandon it: valids drop on the next edge and no data_ok is issued.

Structure
REQ-040 AXI burst/size encodings and the state enumeration SHALL live in a shared cache_axi_pkg.
REQ-041 The wstrb generator SHALL be the sub-module strb_gen, shared with the d-cache bridge.

Verification
REQ-050 Read, arready=1, rvalid two cycles after AR, rdata=32'h1234_5678 -> data_ok one cycle, cache_inst_rdata=32'h1234_5678, araddr=latched addr, arsize=3'b010.
REQ-051 Write byte, addr=32'hBFC0_0003, arready held 0, awready 3 cycles before wready -> wstrb=4'b1000, awvalid drops before wvalid, data_ok on bvalid.
REQ-052 Write half, addr=...02, wready before awready -> wstrb=4'b1100, B entered only after both handshakes.
REQ-053 req held high in R -> addr_ok=0 until the IDLE cycle after data_ok; the second request is then accepted.
REQ-054 rst asserted in B with bvalid pending -> next cycle IDLE, bready=0, no data_ok.
REQ-055 Change cache_inst_addr/wdata after addr_ok -> araddr/awaddr/wdata unchanged.
